// File: rtl/bus_rec_scan_if.sv
// Handshake/bus bundle between the pending-flag register, bus_rec_scan and the readout stage.
interface bus_rec_scan_if #(
   parameter int N_BUS = 32,
   parameter int SEL_W = 5
);
   logic             scan_en;
   logic [N_BUS-1:0] pend_in;
   logic             grant_valid;
   logic             grant_ack;
   logic [SEL_W-1:0] bus_rec_select;
   logic             rst_bus_sig;
   logic             busy;
   logic             timeout_err;

   modport slave (
      input  scan_en, pend_in, grant_ack,
      output grant_valid, bus_rec_select, rst_bus_sig, busy, timeout_err
   );

   modport master (
      output scan_en, pend_in, grant_ack,
      input  grant_valid, bus_rec_select, rst_bus_sig, busy, timeout_err
   );
endinterface

// File: rtl/bus_rec_scan.sv
// Round-robin scanner over the per-bus "message received" flags; grants one bus at a time
// and pulses rst_bus_sig to clear it. Optional GRANT timeout: BUS_REC_SCAN_TIMEOUT_EN.
module bus_rec_scan #(
   parameter int N_BUS       = 32,
   parameter int SEL_W       = 5,
   parameter int TIMEOUT_CYC = 1023
) (
   input logic          clk,
   input logic          rst,
   bus_rec_scan_if.slave bus
);
   localparam int CW = SEL_W + 1;

   if (TIMEOUT_CYC < 1 || N_BUS > (1 << SEL_W)) begin : g_bad_cfg
      $error("bus_rec_scan: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, GRANT, CLEAR, SETTLE} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [SEL_W-1:0] sel_q, sel_nxt;
   logic             gv_q, gv_nxt;
   logic             rsb_q, rsb_nxt;
   logic             te_q, te_nxt;
   logic [SEL_W-1:0] hit;
   logic             found;
   logic [CW-1:0]    cand;

`ifdef BUS_REC_SCAN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] cnt, cnt_nxt;
`endif

   // Walk downward so the lowest offset from ptr is the last (winning) assignment.
   always_comb begin
      hit   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = N_BUS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + CW'(i);
         if (cand >= CW'(N_BUS)) cand = cand - CW'(N_BUS);
         if (bus.pend_in[cand[SEL_W-1:0]]) begin
            hit   = cand[SEL_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel_q;
      gv_nxt    = gv_q;
      rsb_nxt   = 1'b0;
      te_nxt    = 1'b0;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (bus.scan_en && found) begin
               sel_nxt   = hit;
               gv_nxt    = 1'b1;
               state_nxt = GRANT;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         GRANT: begin
            if (bus.grant_ack) begin
               gv_nxt    = 1'b0;
               rsb_nxt   = 1'b1;
               state_nxt = CLEAR;
            end
`ifdef BUS_REC_SCAN_TIMEOUT_EN
            // Ack on the terminal cycle wins over the forced drop.
            else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
               gv_nxt    = 1'b0;
               rsb_nxt   = 1'b1;
               te_nxt    = 1'b1;
               state_nxt = CLEAR;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
`endif
         end
         CLEAR: begin
            ptr_nxt   = (sel_q == SEL_W'(N_BUS - 1)) ? '0 : sel_q + 1'b1;
            state_nxt = SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         sel_q <= '0;
         gv_q  <= 1'b0;
         rsb_q <= 1'b0;
         te_q  <= 1'b0;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel_q <= sel_nxt;
         gv_q  <= gv_nxt;
         rsb_q <= rsb_nxt;
         te_q  <= te_nxt;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
         cnt   <= cnt_nxt;
`endif
      end
   end

   assign bus.grant_valid    = gv_q;
   assign bus.bus_rec_select = sel_q;
   assign bus.rst_bus_sig    = rsb_q;
   assign bus.busy           = (state != IDLE);
   assign bus.timeout_err    = te_q;
endmodule

// File: tb/tb_bus_rec_scan.sv
// Directed table-driven bench for bus_rec_scan plus multi-cycle corner sequences.
module tb_bus_rec_scan;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
   localparam int TC = 4;
`else
   localparam int TC = 1023;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   bus_rec_scan_if #(.N_BUS(32), .SEL_W(5)) bif ();

   bus_rec_scan #(.N_BUS(32), .SEL_W(5), .TIMEOUT_CYC(TC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] pend;
      logic        ack;
      logic        gv;
      logic [4:0]  sel;
      logic        rsb;
      logic        busy;
   } vec_t;

   vec_t vt[18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_grant(input string name);
      for (int i = 0; i < 8 && !bif.grant_valid; i++) tick();
      chk(name, int'(bif.grant_valid), 1);
   endtask

   initial begin
      int exp_rr[6];
      int gaps;
      int gv_cnt;
      int drop_bad;

      bif.scan_en   = 1'b1;
      bif.pend_in   = 32'hFFFF_FFFF;
      bif.grant_ack = 1'b0;

      vt[0]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1};
      vt[1]  = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};
      vt[2]  = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
      vt[3]  = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1};
      vt[5]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1};
      vt[6]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1};
      vt[7]  = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd8, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd8, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 32'h0000_0201, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1};
      vt[10] = '{1'b1, 32'h0000_0201, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1};
      vt[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd9, 1'b0, 1'b1};
      vt[12] = '{1'b0, 32'h0000_0201, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0};
      vt[13] = '{1'b0, 32'h0000_0201, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0};
      vt[14] = '{1'b1, 32'h0000_0201, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1};
      vt[15] = '{1'b1, 32'h0000_0201, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};
      vt[16] = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
      vt[17] = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

      // Reset with every flag set
      rst = 1'b0;
      tick();
      tick();
      chk("rst_gv",   int'(bif.grant_valid), 0);
      chk("rst_sel",  int'(bif.bus_rec_select), 0);
      chk("rst_rsb",  int'(bif.rst_bus_sig), 0);
      chk("rst_busy", int'(bif.busy), 0);
      chk("rst_te",   int'(bif.timeout_err), 0);
      rst = 1'b1;

      foreach (vt[i]) begin
         bif.scan_en   = vt[i].en;
         bif.pend_in   = vt[i].pend;
         bif.grant_ack = vt[i].ack;
         tick();
         chk($sformatf("vec%0d_gv", i),   int'(bif.grant_valid),    int'(vt[i].gv));
         chk($sformatf("vec%0d_sel", i),  int'(bif.bus_rec_select), int'(vt[i].sel));
         chk($sformatf("vec%0d_rsb", i),  int'(bif.rst_bus_sig),    int'(vt[i].rsb));
         chk($sformatf("vec%0d_busy", i), int'(bif.busy),           int'(vt[i].busy));
         chk($sformatf("vec%0d_te", i),   int'(bif.timeout_err),    0);
      end

      // Round-robin with wrap, always acking
      exp_rr = '{0, 1, 31, 0, 1, 31};
      bif.scan_en = 1'b0;
      do_reset();
      bif.pend_in   = 32'h8000_0003;
      bif.grant_ack = 1'b1;
      bif.scan_en   = 1'b1;
      for (int k = 0; k < 6; k++) begin
         gaps = 0;
         for (int i = 0; i < 8 && !bif.grant_valid; i++) begin
            tick();
            gaps++;
         end
         chk($sformatf("rr%0d_gv", k), int'(bif.grant_valid), 1);
         chk($sformatf("rr%0d_sel", k), int'(bif.bus_rec_select), exp_rr[k]);
         if (k > 0) chk($sformatf("rr%0d_spacing", k), gaps + 1, 4);
         tick();
         chk($sformatf("rr%0d_rsb", k), int'(bif.rst_bus_sig), 1);
      end
      bif.grant_ack = 1'b0;
      bif.scan_en   = 1'b0;
      tick(); tick();

      // Hold with scan_en low, then drop scan_en mid-GRANT
      do_reset();
      bif.pend_in = 32'h10;
      drop_bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bif.grant_valid || bif.busy) drop_bad++;
      end
      chk("hold_no_grant", drop_bad, 0);
      bif.scan_en = 1'b1;
      tick();
      chk("hold_sel", int'(bif.bus_rec_select), 4);
      bif.scan_en = 1'b0;
      bif.pend_in = 32'h0;
      tick(); tick(); tick();
      chk("hold_gv_kept", int'(bif.grant_valid), 1);
      bif.grant_ack = 1'b1;
      tick();
      chk("hold_complete_rsb", int'(bif.rst_bus_sig), 1);
      bif.grant_ack = 1'b0;
      tick(); tick();
      chk("hold_idle", int'(bif.busy), 0);

      // Reset mid-GRANT: ptr is 5 here, reset must bring it back to 0
      bif.pend_in = 32'h20;
      bif.scan_en = 1'b1;
      tick();
      chk("midrst_sel", int'(bif.bus_rec_select), 5);
      rst = 1'b0;
      tick();
      chk("midrst_gv",   int'(bif.grant_valid), 0);
      chk("midrst_busy", int'(bif.busy), 0);
      chk("midrst_sel0", int'(bif.bus_rec_select), 0);
      rst = 1'b1;
      bif.pend_in = 32'h21;
      tick();
      chk("midrst_no_rsb", int'(bif.rst_bus_sig), 0);
      chk("midrst_next_sel", int'(bif.bus_rec_select), 0);
      bif.grant_ack = 1'b1;
      tick();
      bif.grant_ack = 1'b0;
      tick(); tick();

      // GRANT with no ack
      bif.pend_in = 32'h40;
      bif.scan_en = 1'b1;
      wait_grant("noack_grant");
      chk("noack_sel", int'(bif.bus_rec_select), 6);
      bif.pend_in = 32'h0;
`ifdef BUS_REC_SCAN_TIMEOUT_EN
      gv_cnt = 0;
      for (int i = 0; i < 20 && bif.grant_valid; i++) begin
         gv_cnt++;
         tick();
      end
      chk("to_gv_cycles", gv_cnt, 4);
      chk("to_rsb", int'(bif.rst_bus_sig), 1);
      chk("to_err", int'(bif.timeout_err), 1);
      tick();
      chk("to_err_pulse", int'(bif.timeout_err), 0);
      tick(); tick();
      // Ack on terminal cycle takes priority
      bif.pend_in = 32'h80;
      wait_grant("to_ack_grant");
      tick(); tick(); tick();
      chk("to_ack_gv", int'(bif.grant_valid), 1);
      bif.grant_ack = 1'b1;
      tick();
      bif.grant_ack = 1'b0;
      chk("to_ack_rsb", int'(bif.rst_bus_sig), 1);
      chk("to_ack_err", int'(bif.timeout_err), 0);
`else
      drop_bad = 0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (!bif.grant_valid || bif.timeout_err || bif.rst_bus_sig) drop_bad++;
      end
      chk("noto_held", drop_bad, 0);
      bif.grant_ack = 1'b1;
      tick();
      bif.grant_ack = 1'b0;
      chk("noto_rsb", int'(bif.rst_bus_sig), 1);
      chk("noto_err", int'(bif.timeout_err), 0);
      gv_cnt = 0;
`endif
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
